// File: rtl/unary_dot_mac_if.sv
`default_nettype none
// ============================================================================
//  Module   : unary_dot_mac_if
//  Purpose  : Frame-input / unary-output handshake bundle for unary_dot_mac.
//  Revision : 1.0  initial release
// ============================================================================
interface unary_dot_mac_if #(
    parameter int LANES    = 2,
    parameter int ACC_BITS = 12
);
    logic                in_valid;
    logic                in_ready;
    logic [LANES-1:0]    a;
    logic [LANES-1:0]    b;
    logic                c;
    logic                acc_mode;
    logic                acc_clear;
    logic                out;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic                done;
    logic [ACC_BITS-1:0] result_bin;
    logic                sat;

    modport master (
        output in_valid, a, b, c, acc_mode, acc_clear, out_ready,
        input  in_ready, out, out_valid, out_last, done, result_bin, sat
    );

    modport slave (
        input  in_valid, a, b, c, acc_mode, acc_clear, out_ready,
        output in_ready, out, out_valid, out_last, done, result_bin, sat
    );
endinterface
`default_nettype wire

// File: rtl/unary_dot_mac.sv
`default_nettype none
// ============================================================================
//  Module   : unary_dot_mac
//  Purpose  : Multi-lane unary dot product plus bias, saturating accumulate,
//             result streamed out as unary beats with backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module unary_dot_mac #(
    parameter int BIN_BITS = 4,
    parameter int LANES    = 2,
    parameter int ACC_BITS = 12
) (
    input  wire logic         clk,
    input  wire logic         reset,
    unary_dot_mac_if.slave    bus
);

    localparam int c_U_BITS = 2**BIN_BITS;
    localparam int c_SW     = BIN_BITS + 1;
    localparam int c_KW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_PW     = 2 * BIN_BITS;
    localparam int c_WW     = ((ACC_BITS > c_PW) ? ACC_BITS : c_PW) + 2;

    localparam logic [ACC_BITS-1:0] c_ACC_MAX   = '1;
    localparam logic [c_SW-1:0]     c_SAMP_LAST = c_SW'(c_U_BITS - 1);
    localparam logic [c_KW-1:0]     c_K_LAST    = c_KW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_COMPUTE = 2'd2,
        S_EMIT    = 2'd3
    } state_t;

    state_t              r_state;
    logic [BIN_BITS-1:0] r_cnt_a [LANES];
    logic [BIN_BITS-1:0] r_cnt_b [LANES];
    logic [BIN_BITS-1:0] r_cnt_c;
    logic [c_SW-1:0]     r_samp;
    logic [c_KW-1:0]     r_k;
    logic [ACC_BITS-1:0] r_acc;
    logic [ACC_BITS-1:0] r_remain;
    logic [ACC_BITS-1:0] r_result;
    logic                r_sat;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_done;

    logic [c_PW-1:0]     w_prod;
    logic [c_WW-1:0]     w_sum;
    logic                w_ovf;
    logic                w_k_last;
    logic [ACC_BITS-1:0] w_acc_next;

    function automatic logic [BIN_BITS-1:0] f_inc(input logic [BIN_BITS-1:0] v,
                                                  input logic               bit_in);
        return (bit_in && (v != '1)) ? v + 1'b1 : v;
    endfunction

    // One lane product per COMPUTE cycle; the bias joins on the last lane.
    always_comb begin
        w_k_last   = (r_k == c_K_LAST);
        w_prod     = c_PW'(r_cnt_a[r_k]) * c_PW'(r_cnt_b[r_k]);
        w_sum      = c_WW'(r_acc) + c_WW'(w_prod) + (w_k_last ? c_WW'(r_cnt_c) : '0);
        w_ovf      = (w_sum > c_WW'(c_ACC_MAX));
        w_acc_next = w_ovf ? c_ACC_MAX : w_sum[ACC_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < LANES; i++) begin
                r_cnt_a[i] <= '0;
                r_cnt_b[i] <= '0;
            end
            r_cnt_c     <= '0;
            r_samp      <= '0;
            r_k         <= '0;
            r_acc       <= '0;
            r_remain    <= '0;
            r_result    <= '0;
            r_sat       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.acc_clear) begin
                        r_acc <= '0;
                        r_sat <= 1'b0;
                    end
                    if (bus.in_valid) begin
                        if (bus.acc_clear || !bus.acc_mode) begin
                            r_acc <= '0;
                        end
                        for (int i = 0; i < LANES; i++) begin
                            r_cnt_a[i] <= BIN_BITS'(bus.a[i]);
                            r_cnt_b[i] <= BIN_BITS'(bus.b[i]);
                        end
                        r_cnt_c <= BIN_BITS'(bus.c);
                        r_samp  <= c_SW'(1);
                        r_state <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    if (!bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        r_k        <= '0;
                        r_state    <= S_COMPUTE;
                    end else begin
                        for (int i = 0; i < LANES; i++) begin
                            r_cnt_a[i] <= f_inc(r_cnt_a[i], bus.a[i]);
                            r_cnt_b[i] <= f_inc(r_cnt_b[i], bus.b[i]);
                        end
                        r_cnt_c <= f_inc(r_cnt_c, bus.c);
                        r_samp  <= r_samp + 1'b1;
                        // This sample fills the window.
                        if (r_samp == c_SAMP_LAST) begin
                            r_in_ready <= 1'b0;
                            r_k        <= '0;
                            r_state    <= S_COMPUTE;
                        end
                    end
                end

                S_COMPUTE: begin
                    r_acc <= w_acc_next;
                    if (w_ovf) begin
                        r_sat <= 1'b1;
                    end
                    if (w_k_last) begin
                        r_result <= w_acc_next;
                        if (w_acc_next == '0) begin
                            r_done     <= 1'b1;
                            r_in_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_out_last  <= (w_acc_next == ACC_BITS'(1));
                            r_remain    <= w_acc_next;
                            r_state     <= S_EMIT;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end

                S_EMIT: begin
                    if (bus.out_ready) begin
                        if (r_remain == ACC_BITS'(1)) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_done      <= 1'b1;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_remain   <= r_remain - 1'b1;
                            r_out_last <= (r_remain == ACC_BITS'(2));
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Every emitted beat carries a 1, so the data bit simply mirrors valid.
    assign bus.out        = r_out_valid;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_last   = r_out_last;
    assign bus.in_ready   = r_in_ready;
    assign bus.done       = r_done;
    assign bus.result_bin = r_result;
    assign bus.sat        = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_unary_dot_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unary_dot_mac
//  Purpose  : Directed self-checking bench for unary_dot_mac (12-bit and 8-bit acc).
//  Revision : 1.0  initial release
// ============================================================================
module tb_unary_dot_mac;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    unary_dot_mac_if #(.LANES(2), .ACC_BITS(12)) bus  ();
    unary_dot_mac_if #(.LANES(2), .ACC_BITS(8))  bus8 ();

    unary_dot_mac #(.BIN_BITS(4), .LANES(2), .ACC_BITS(12)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    unary_dot_mac #(.BIN_BITS(4), .LANES(2), .ACC_BITS(8)) dut8 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus8)
    );

    // The narrow-accumulator instance sees exactly the same stimulus.
    assign bus8.in_valid  = bus.in_valid;
    assign bus8.a         = bus.a;
    assign bus8.b         = bus.b;
    assign bus8.c         = bus.c;
    assign bus8.acc_mode  = bus.acc_mode;
    assign bus8.acc_clear = bus.acc_clear;
    assign bus8.out_ready = bus.out_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ones occupy the first n cycles of each lane; one idle cycle closes the frame.
    task automatic send_frame(input int a0, input int a1, input int b0, input int b1,
                              input int cc, input bit mode, input int len);
        for (int j = 0; j < len; j++) begin
            bus.in_valid = 1'b1;
            bus.a        = {(j < a1), (j < a0)};
            bus.b        = {(j < b1), (j < b0)};
            bus.c        = (j < cc);
            bus.acc_mode = mode;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.c        = 1'b0;
        bus.acc_mode = 1'b0;
    endtask

    task automatic run_result(input string tag, input int exp, input bit toggle,
                              input int lat_exp, input int budget);
        int   cyc, xfers, last_at, dones, valids, first_valid, stall_bad, shape_bad;
        bit   pv_stall;
        logic pv, po, pl;
        cyc = 0; xfers = 0; last_at = -1; dones = 0; valids = 0;
        first_valid = -1; stall_bad = 0; shape_bad = 0; pv_stall = 1'b0;
        pv = 1'b0; po = 1'b0; pl = 1'b0;
        while (dones == 0 && cyc < budget) begin
            tick();
            cyc++;
            if (pv_stall && (bus.out_valid !== pv || bus.out !== po || bus.out_last !== pl))
                stall_bad++;
            if (bus.out_valid === 1'b1 && bus.out !== 1'b1)
                shape_bad++;
            if (bus.out_valid !== 1'b1 && (bus.out !== 1'b0 || bus.out_last !== 1'b0))
                shape_bad++;
            if (bus.done === 1'b1)
                dones++;
            if (bus.out_valid === 1'b1) begin
                valids++;
                if (first_valid < 0) first_valid = cyc;
            end
            bus.out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                xfers++;
                if (bus.out_last === 1'b1) last_at = xfers;
            end
            pv_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
            pv = bus.out_valid;
            po = bus.out;
            pl = bus.out_last;
        end
        chk({tag, "_done_seen"}, dones, 1);
        chk({tag, "_beats"}, xfers, exp);
        chk({tag, "_last_beat"}, last_at, (exp > 0) ? exp : -1);
        chk({tag, "_result_bin"}, bus.result_bin, exp);
        chk({tag, "_stall_hold"}, stall_bad, 0);
        chk({tag, "_out_shape"}, shape_bad, 0);
        if (exp == 0) chk({tag, "_no_valid"}, valids, 0);
        if (lat_exp > 0) chk({tag, "_latency"}, first_valid, lat_exp);
        bus.out_ready = 1'b1;
        tick();
        chk({tag, "_done_1cyc"}, bus.done, 0);
        chk({tag, "_in_ready_idle"}, bus.in_ready, 1);
    endtask

    initial begin
        int dn;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c         = 1'b0;
        bus.acc_mode  = 1'b0;
        bus.acc_clear = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sat", bus.sat, 0);
        chk("rst_result", bus.result_bin, 0);
        rst = 1'b0;
        tick();

        // 3*2 + 6 = 12
        send_frame(3, 0, 2, 0, 6, 1'b0, 6);
        run_result("t1", 12, 1'b0, 3, 40);

        // 4*15 + 15*15 + 3 = 288
        send_frame(4, 15, 15, 15, 3, 1'b0, 15);
        run_result("t2", 288, 1'b0, 3, 400);
        chk("t2_sat", bus.sat, 0);

        // All-zero frame: no beats, done only
        send_frame(0, 0, 0, 0, 0, 1'b0, 3);
        run_result("t3a", 0, 1'b0, 0, 20);

        // Full 16-cycle window: a0 saturates at 15, b0 once; 17th cycle ignored
        for (int j = 0; j < 17; j++) begin
            bus.in_valid = 1'b1;
            bus.a        = 2'b01;
            bus.b        = {1'b0, (j == 0 || j == 16)};
            bus.c        = (j == 16);
            tick();
            if (j == 15) chk("t3b_in_ready_closed", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.c        = 1'b0;
        run_result("t3b", 15, 1'b0, 0, 40);

        // Accumulation modes
        send_frame(3, 0, 2, 0, 1, 1'b0, 3);
        run_result("t4a", 7, 1'b0, 3, 30);
        send_frame(1, 0, 1, 0, 0, 1'b1, 1);
        run_result("t4b", 8, 1'b0, 3, 30);
        bus.acc_clear = 1'b1;
        tick();
        bus.acc_clear = 1'b0;
        chk("t4_clear_sat8", bus8.sat, 0);
        send_frame(2, 0, 2, 0, 0, 1'b1, 2);
        run_result("t4c", 4, 1'b0, 3, 30);

        // Backpressure: 1*1 + 4 = 5 with out_ready toggling
        send_frame(1, 0, 1, 0, 4, 1'b0, 4);
        run_result("t5", 5, 1'b1, 3, 40);

        // 15*15 + 15*15 + 15 = 465: fits 12 bits, saturates 8 bits
        send_frame(15, 15, 15, 15, 15, 1'b0, 15);
        run_result("t6", 465, 1'b0, 3, 600);
        chk("t6_sat12", bus.sat, 0);
        chk("t6_result8", bus8.result_bin, 255);
        chk("t6_sat8", bus8.sat, 1);

        // Reset in the middle of EMIT
        send_frame(3, 0, 2, 0, 6, 1'b0, 6);
        for (int i = 0; i < 10 && bus.out_valid !== 1'b1; i++) tick();
        chk("t6r_emit_reached", bus.out_valid, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6r_out_valid", bus.out_valid, 0);
        chk("t6r_in_ready", bus.in_ready, 1);
        chk("t6r_result", bus.result_bin, 0);
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done === 1'b1) dn++;
            tick();
        end
        chk("t6r_no_done", dn, 0);
        chk("t6r_stay_idle", bus.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
